// File: rtl/bias_pkg.sv
// Shared widths, state encoding and saturation helpers for the bias datapath
// (first-layer forward and backward blocks).
package bias_pkg;

  localparam int NWBITS_DEF     = 16;
  localparam int COUNT_BIT1_DEF = 10;
  localparam int BATCH_BITS_DEF = 2;
  localparam int ERRW_DEF       = NWBITS_DEF + COUNT_BIT1_DEF;
  localparam int ACCW_DEF       = ERRW_DEF + BATCH_BITS_DEF;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCALE = 2'd1,
    ISSUE = 2'd2
  } bias_state_e;

  // Signed clip limits for a w-bit two's-complement result.
  function automatic logic signed [63:0] sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/bias_delta1_sat_shift.sv
// Arithmetic right shift with saturation to OUT_W bits and a clip flag.
// BIAS_DELTA_ROUND_EN selects round-half-up instead of floor.
module sat_shift
  import bias_pkg::*;
#(
  parameter int IN_W  = ACCW_DEF,
  parameter int OUT_W = NWBITS_DEF,
  parameter int SHIFT = 6
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] shifted;
  logic signed [63:0]   wide;
  logic signed [63:0]   hi;
  logic signed [63:0]   lo;

  always_comb begin
    hi  = sat_hi(OUT_W);
    lo  = sat_lo(OUT_W);
    // One guard bit so the rounding add cannot wrap.
    ext = {din[IN_W-1], din};
`ifdef BIAS_DELTA_ROUND_EN
    ext = ext + ((IN_W+1)'(1) << (SHIFT - 1));
`endif
    shifted = ext >>> SHIFT;
    wide    = {{(63-IN_W){shifted[IN_W]}}, shifted};
    if (wide > hi) begin
      dout = hi[OUT_W-1:0];
      clip = 1'b1;
    end else if (wide < lo) begin
      dout = lo[OUT_W-1:0];
      clip = 1'b1;
    end else begin
      dout = wide[OUT_W-1:0];
      clip = 1'b0;
    end
  end

endmodule

// File: rtl/bias_delta1.sv
// First-layer bias correction: ReLU-gated error accumulation over a batch,
// LR shift + saturation, one-cycle update strobe. Option: BIAS_DELTA_ROUND_EN.
module bias_delta1
  import bias_pkg::*;
#(
  parameter int NWBITS     = 16,
  parameter int COUNT_BIT1 = 10,
  parameter int BATCH      = 4,
  parameter int BATCH_BITS = 2,
  parameter int LR_SHIFT   = 6
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                sample_valid,
  input  logic signed [NWBITS+COUNT_BIT1-1:0] err,
  input  logic signed [NWBITS+COUNT_BIT1-1:0] before_relu,
  input  logic                                flush,
  input  logic                                hold,
  output logic                                update_bias,
  output logic signed [NWBITS-1:0]            delta_bias,
  output logic                                sat_flag,
  output logic                                overrun
);

  localparam int ERRW = NWBITS + COUNT_BIT1;
  localparam int ACCW = ERRW + BATCH_BITS;
  localparam int CW   = BATCH_BITS + 1;

  bias_state_e              state_q, state_d;
  logic signed [ACCW-1:0]   acc_q, acc_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic signed [NWBITS-1:0] delta_q, delta_d;
  logic                     sat_q, sat_d;
  logic                     ovr_q, ovr_d;

  logic                     relu_on;
  logic signed [ACCW-1:0]   contrib;
  logic [CW-1:0]            cnt_inc;
  logic signed [NWBITS-1:0] scaled;
  logic                     clipped;

  sat_shift #(
    .IN_W  (ACCW),
    .OUT_W (NWBITS),
    .SHIFT (LR_SHIFT)
  ) u_sat_shift (
    .din  (acc_q),
    .dout (scaled),
    .clip (clipped)
  );

  always_comb begin
    relu_on = !before_relu[ERRW-1] && (|before_relu);
    contrib = relu_on ? {{BATCH_BITS{err[ERRW-1]}}, err} : '0;
    cnt_inc = cnt_q + 1'b1;

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    delta_d = delta_q;
    sat_d   = sat_q;
    ovr_d   = sample_valid && (state_q != ACCUM);

    unique case (state_q)
      ACCUM: begin
        if (sample_valid) begin
          acc_d = acc_q + contrib;
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(BATCH) || flush) state_d = SCALE;
        end else if (flush && cnt_q != '0) begin
          state_d = SCALE;
        end
      end
      SCALE: begin
        delta_d = scaled;
        sat_d   = clipped;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (!hold) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      delta_q <= '0;
      sat_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      delta_q <= delta_d;
      sat_q   <= sat_d;
      ovr_q   <= ovr_d;
    end
  end

  // Strobe is decoded from state so it lands in the cycle hold drops.
  assign update_bias = (state_q == ISSUE) && !hold && !reset;
  assign delta_bias  = delta_q;
  assign sat_flag    = sat_q;
  assign overrun     = ovr_q;

endmodule

// File: doc/bias_delta1.md
Name: bias_delta1

Overview:
- Backward-direction counterpart of the first-layer bias adder: computes the bias correction that is applied with the `update_bias` pulse.
- Accumulates ReLU-gated error terms over a mini-batch, scales the sum by the learning rate (arithmetic right shift) and saturates it to NWBITS.
- Then issues `delta_bias` with a one-cycle `update_bias` pulse.
- Sits between the backprop error path and the first-layer bias register.

Parameters:
- NWBITS, 16, width of `delta_bias` and of the bias register.
- COUNT_BIT1, 10, extra sum bits; error/pre-activation width ERRW = NWBITS+COUNT_BIT1.
- BATCH, 4, samples per update (≥1).
- BATCH_BITS, 2, ceil(log2(BATCH)), minimum 1.
- LR_SHIFT, 6, learning-rate right shift (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  one backprop sample present this cycle.
- err  in  ERRW signed  error term for this neuron.
- before_relu  in  ERRW signed  pre-activation from the forward pass for the same sample.
- flush  in  1  issue an update from a partial batch.
- hold  in  1  bias register busy; defer the pulse.
- update_bias  out  1  one-cycle update strobe.
- delta_bias  out  NWBITS signed  scaled, saturated correction.
- sat_flag  out  1  last issued delta was clipped.
- overrun  out  1  one-cycle pulse: sample dropped while not in ACCUM.

Behaviour:
- Reset (sync, active-high, overrides all):
  - state = ACCUM; acc = 0; cnt = 0.
  - update_bias = 0; delta_bias = 0; sat_flag = 0; overrun = 0.
  - Reset during SCALE or ISSUE abandons the update; no pulse is produced.
- Accumulator: ACCW = ERRW+BATCH_BITS, signed, cannot overflow.
- Gating: contribution = err when before_relu > 0, else 0 (zero pre-activation counts as masked).
- ACCUM state:
  - On sample_valid: acc += contribution; cnt += 1.
  - When the accepted sample makes cnt reach BATCH, next state is SCALE.
  - On flush with cnt ≥ 1, or with a same-cycle sample: that sample is included, next state is SCALE.
  - On flush with cnt = 0 and no sample: ignored, no zero update.
- SCALE state (one cycle):
  - s = acc >>> LR_SHIFT (arithmetic, floor).
  - Clip to [-2^(NWBITS-1), 2^(NWBITS-1)-1].
  - Register delta_bias and sat_flag (1 if clipped, else 0). Next state is ISSUE.
- ISSUE state:
  - hold = 1: stay in ISSUE, update_bias = 0.
  - hold = 0: update_bias = 1 for exactly one cycle; acc and cnt cleared; next state ACCUM.
- Outputs:
  - delta_bias and sat_flag are stable from SCALE+1 until the next SCALE.
- Latency:
  - Last sample accepted at edge T: update_bias high in cycle T+2 when hold is low.
  - Each cycle of hold adds one cycle.
- Drops and simultaneous events:
  - sample_valid in SCALE or ISSUE drops the sample and pulses overrun next cycle.
  - flush outside ACCUM is ignored.
  - A sample accepted in the same cycle the pulse issues is not possible, since the pulse is in ISSUE.
- Back-to-back: the first sample may be accepted in the cycle after the pulse.

Optional Feature:
- Macro: BIAS_DELTA_ROUND_EN.
- Defined: SCALE computes (acc + 2^(LR_SHIFT-1)) >>> LR_SHIFT, i.e. round-half-up, before saturation.
  - The adder has one extra bit, so it cannot overflow.
- Undefined: truncating floor shift only.
- Timing and handshake are identical either way.

Decomposition:
- Shared package bias_pkg holds:
  - state encoding localparams: ACCUM=2'd0, SCALE=2'd1, ISSUE=2'd2.
  - ERRW/ACCW width constants.
  - A saturation-limit helper function.
  - The first-layer modules reuse the widths from it.
- One natural sub-module: sat_shift, combinational.
  - Shift, optional rounding and clip, plus the clip flag.
  - Parameterised by in width, out width and shift; instantiated once in SCALE.

Test Plan (defaults: BATCH=4, LR_SHIFT=6):
- Full batch: 4 samples, err=64, before_relu=5, hold=0 → acc=256; update_bias pulse 2 cycles after the last sample; delta_bias=4, sat_flag=0.
- Masking: 4 samples, err=64, with before_relu = 5, -3, 0, 7 → acc=128, delta_bias=2.
- Saturation: 4 samples, err=2^24, before_relu=1 → 2^20 clipped to 32767, sat_flag=1; repeat with err=-2^24 → -32768, sat_flag=1.
- Handshake and drops: hold=1 for 3 cycles while in ISSUE → pulse delayed to T+5 and lasts exactly 1 cycle; sample_valid during hold → overrun pulse, that sample absent from the next batch.
- Flush and rounding:
  - flush after 1 sample err=100, before_relu=1 → delta_bias=1 (2 with BIAS_DELTA_ROUND_EN).
  - 4 samples err=-1 → delta_bias=-1 (0 with BIAS_DELTA_ROUND_EN).
  - flush with cnt=0 → no pulse.
- Reset mid-operation: reset asserted in ISSUE with hold=1 → no pulse, delta_bias=0; 4 fresh samples then produce a correct update.
